// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and encodings for the multicycle control FSM
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC_R, ALUWB, EXEC_I, IWB, BRANCH, JUMP, HALT
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_J     = 4'h5;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLT = 4'h5;

  localparam logic [3:0] FN_ADD = 4'h0;
  localparam logic [3:0] FN_SUB = 4'h1;
  localparam logic [3:0] FN_AND = 4'h2;
  localparam logic [3:0] FN_OR  = 4'h3;
  localparam logic [3:0] FN_XOR = 4'h4;
  localparam logic [3:0] FN_SLT = 4'h5;

  typedef enum logic [1:0] {
    ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  } aluop_e;

endpackage

// File: rtl/mc_aludec.sv
// rtl/mc_aludec.sv - ALU operation decode from FSM aluop and R-type funct
module mc_aludec
  import mc_pkg::*;
(
  input  aluop_e      aluop_i,
  input  logic [3:0]  funct_i,
  output logic [3:0]  alucontrol_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alucontrol_o = ALU_ADD;
          FN_SUB:  alucontrol_o = ALU_SUB;
          FN_AND:  alucontrol_o = ALU_AND;
          FN_OR:   alucontrol_o = ALU_OR;
          FN_XOR:  alucontrol_o = ALU_XOR;
          FN_SLT:  alucontrol_o = ALU_SLT;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle CPU control FSM with memory wait timeout
module mc_controller
  import mc_pkg::*;
#(
  parameter int n        = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [3:0]  op_i,
  input  logic [3:0]  funct_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pcwrite_o,
  output logic        irwrite_o,
  output logic        iord_o,
  output logic        memread_o,
  output logic        memwrite_o,
  output logic        memtoreg_o,
  output logic        regdst_o,
  output logic        regwrite_o,
  output logic        alusrca_o,
  output logic [1:0]  alusrcb_o,
  output logic [1:0]  pcsrc_o,
  output logic [3:0]  alucontrol_o,
  output logic        halted_o,
  output logic        bus_err_o
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  // PC steps one 32-bit word through the const-4 leg; no wider leg exists
  localparam logic [1:0] SRCB_PC_INC = (n == 32) ? SRCB_FOUR : SRCB_FOUR;

  state_e          state_q, state_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            bus_err_q, bus_err_d;
  logic            waiting, timeout;
  aluop_e          aluop;

  assign waiting = (state_q == FETCH || state_q == MEMRD || state_q == MEMWR) && !mem_ready_i;
  assign timeout = waiting && (wait_q == CW'(WAIT_MAX));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bus_err_d = bus_err_q | timeout;
    wait_d    = '0;
    if (waiting) wait_d = (wait_q == CW'(WAIT_MAX)) ? wait_q : wait_q + CW'(1);
    if (timeout) begin
      state_d = HALT;
    end else begin
      case (state_q)
        FETCH:  if (mem_ready_i) state_d = DECODE;
        DECODE: begin
          case (op_i)
            OP_RTYPE:      state_d = EXEC_R;
            OP_ADDI:       state_d = EXEC_I;
            OP_LW, OP_SW:  state_d = MEMADR;
            OP_BEQ:        state_d = BRANCH;
            OP_J:          state_d = JUMP;
            default:       state_d = HALT;
          endcase
        end
        MEMADR: state_d = (op_i == OP_LW) ? MEMRD : MEMWR;
        MEMRD:  if (mem_ready_i) state_d = MEMWB;
        MEMWR:  if (mem_ready_i) state_d = FETCH;
        EXEC_R: state_d = ALUWB;
        EXEC_I: state_d = IWB;
        MEMWB, ALUWB, IWB, BRANCH, JUMP: state_d = FETCH;
        default: state_d = HALT;
      endcase
    end
  end

  always_comb begin
    pcwrite_o  = 1'b0;
    irwrite_o  = 1'b0;
    iord_o     = 1'b0;
    memread_o  = 1'b0;
    memwrite_o = 1'b0;
    memtoreg_o = 1'b0;
    regdst_o   = 1'b0;
    regwrite_o = 1'b0;
    alusrca_o  = 1'b0;
    alusrcb_o  = SRCB_B;
    pcsrc_o    = PCSRC_ALU;
    aluop      = ALUOP_ADD;
    halted_o   = 1'b0;
    if (!reset_i) begin
      case (state_q)
        FETCH: begin
          memread_o = !timeout;
          alusrcb_o = SRCB_PC_INC;
          irwrite_o = mem_ready_i;
          pcwrite_o = mem_ready_i;
        end
        DECODE: alusrcb_o = SRCB_IMM_SH2;
        MEMADR: begin
          alusrca_o = 1'b1;
          alusrcb_o = SRCB_IMM;
        end
        MEMRD: begin
          memread_o = !timeout;
          iord_o    = 1'b1;
        end
        MEMWB: begin
          regwrite_o = 1'b1;
          memtoreg_o = 1'b1;
        end
        MEMWR: begin
          memwrite_o = !timeout;
          iord_o     = 1'b1;
        end
        EXEC_R: begin
          alusrca_o = 1'b1;
          aluop     = ALUOP_FUNCT;
        end
        ALUWB: begin
          regwrite_o = 1'b1;
          regdst_o   = 1'b1;
        end
        EXEC_I: begin
          alusrca_o = 1'b1;
          alusrcb_o = SRCB_IMM;
        end
        IWB:    regwrite_o = 1'b1;
        BRANCH: begin
          alusrca_o = 1'b1;
          aluop     = ALUOP_SUB;
          pcsrc_o   = PCSRC_ALUOUT;
          pcwrite_o = zero_i;
        end
        JUMP: begin
          pcsrc_o   = PCSRC_JUMP;
          pcwrite_o = 1'b1;
        end
        default: halted_o = 1'b1;
      endcase
    end
  end

  assign bus_err_o = bus_err_q && !reset_i;

  mc_aludec u_aludec (
    .aluop_i      (aluop),
    .funct_i      (funct_i),
    .alucontrol_o (alucontrol_o)
  );

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - randomized scoreboard bench for mc_controller
module tb_mc_controller;

  localparam int WAIT_MAX = 15;

  typedef struct packed {
    logic       pcwrite;
    logic       irwrite;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [3:0] alucontrol;
    logic       halted;
    logic       bus_err;
  } out_t;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [3:0]  op_i = 4'h0;
  logic [3:0]  funct_i = 4'h0;
  logic        zero_i = 1'b0;
  logic        mem_ready_i = 1'b0;
  logic        pcwrite_o, irwrite_o, iord_o, memread_o, memwrite_o;
  logic        memtoreg_o, regdst_o, regwrite_o, alusrca_o, halted_o, bus_err_o;
  logic [1:0]  alusrcb_o, pcsrc_o;
  logic [3:0]  alucontrol_o;

  out_t        exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc_no = 0;
  out_t        mon_e, mon_a;
  string       mon_tag;

  mc_controller #(.n(32), .WAIT_MAX(WAIT_MAX)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .op_i(op_i), .funct_i(funct_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .pcwrite_o(pcwrite_o), .irwrite_o(irwrite_o), .iord_o(iord_o),
    .memread_o(memread_o), .memwrite_o(memwrite_o), .memtoreg_o(memtoreg_o),
    .regdst_o(regdst_o), .regwrite_o(regwrite_o), .alusrca_o(alusrca_o),
    .alusrcb_o(alusrcb_o), .pcsrc_o(pcsrc_o), .alucontrol_o(alucontrol_o),
    .halted_o(halted_o), .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: every clock the DUT presents a control word; compare it to the oldest prediction
  always @(negedge clk_i) begin
    cyc_no <= cyc_no + 1;
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      mon_a   = {pcwrite_o, irwrite_o, iord_o, memread_o, memwrite_o, memtoreg_o,
                 regdst_o, regwrite_o, alusrca_o, alusrcb_o, pcsrc_o, alucontrol_o,
                 halted_o, bus_err_o};
      n_checks++;
      if (mon_a !== mon_e) begin
        n_fail++;
        $display("FAIL %s cycle=%0d got=%05h expected=%05h", mon_tag, cyc_no, mon_a, mon_e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired pending=%0d expected=0", exp_q.size());
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] rnd4();
    return 4'($urandom);
  endfunction

  function automatic logic rnd1();
    return 1'($urandom);
  endfunction

  // Funct codes 0..5 name ADD,SUB,AND,OR,XOR,SLT with the same ALU code; anything else adds
  function automatic logic [3:0] ref_alu(input logic [3:0] f);
    return (f <= 4'd5) ? f : 4'd0;
  endfunction

  task automatic cyc(input string tag, input logic rst, input logic [3:0] op,
                     input logic [3:0] fn, input logic z, input logic rdy, input out_t e);
    reset_i     = rst;
    op_i        = op;
    funct_i     = fn;
    zero_i      = z;
    mem_ready_i = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk_i);
    #1;
  endtask

  task automatic fetch_phase(input int nw, output bit to);
    out_t e;
    logic rdy;
    to = 1'b0;
    for (int i = 0; i <= WAIT_MAX; i++) begin
      rdy = (i >= nw);
      e = '0;
      e.alusrcb = 2'b01;
      if (!rdy && i == WAIT_MAX) begin
        cyc("fetch_timeout", 1'b0, rnd4(), rnd4(), rnd1(), 1'b0, e);
        to = 1'b1;
        return;
      end
      e.memread = 1'b1;
      e.pcwrite = rdy;
      e.irwrite = rdy;
      cyc("fetch", 1'b0, rnd4(), rnd4(), rnd1(), rdy, e);
      if (rdy) return;
    end
  endtask

  task automatic mem_phase(input bit wr, input logic [3:0] op, input int nw, output bit to);
    out_t e;
    logic rdy;
    to = 1'b0;
    for (int i = 0; i <= WAIT_MAX; i++) begin
      rdy = (i >= nw);
      e = '0;
      e.iord = 1'b1;
      if (!rdy && i == WAIT_MAX) begin
        cyc(wr ? "memwr_timeout" : "memrd_timeout", 1'b0, op, rnd4(), rnd1(), 1'b0, e);
        to = 1'b1;
        return;
      end
      e.memread  = !wr;
      e.memwrite = wr;
      cyc(wr ? "memwr" : "memrd", 1'b0, op, rnd4(), rnd1(), rdy, e);
      if (rdy) return;
    end
  endtask

  // Result: 0 = instruction retired, 1 = halted on illegal op, 2 = halted on bus error
  task automatic run_instr(input logic [3:0] op, input logic [3:0] fn, input logic z,
                           input int nwf, input int nwm, output int res);
    out_t e;
    bit   to;
    res = 0;
    fetch_phase(nwf, to);
    if (to) begin res = 2; return; end
    e = '0; e.alusrcb = 2'b11;
    cyc("decode", 1'b0, op, rnd4(), rnd1(), rnd1(), e);
    case (op)
      4'h0: begin
        e = '0; e.alusrca = 1'b1; e.alucontrol = ref_alu(fn);
        cyc("exec_r", 1'b0, op, fn, rnd1(), rnd1(), e);
        e = '0; e.regwrite = 1'b1; e.regdst = 1'b1;
        cyc("aluwb", 1'b0, op, rnd4(), rnd1(), rnd1(), e);
      end
      4'h1: begin
        e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
        cyc("exec_i", 1'b0, op, rnd4(), rnd1(), rnd1(), e);
        e = '0; e.regwrite = 1'b1;
        cyc("iwb", 1'b0, op, rnd4(), rnd1(), rnd1(), e);
      end
      4'h2, 4'h3: begin
        e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
        cyc("memadr", 1'b0, op, rnd4(), rnd1(), rnd1(), e);
        mem_phase(op == 4'h3, op, nwm, to);
        if (to) begin res = 2; return; end
        if (op == 4'h2) begin
          e = '0; e.regwrite = 1'b1; e.memtoreg = 1'b1;
          cyc("memwb", 1'b0, op, rnd4(), rnd1(), rnd1(), e);
        end
      end
      4'h4: begin
        e = '0; e.alusrca = 1'b1; e.alucontrol = 4'd1; e.pcsrc = 2'b01; e.pcwrite = z;
        cyc(z ? "branch_taken" : "branch_not_taken", 1'b0, op, rnd4(), z, rnd1(), e);
      end
      4'h5: begin
        e = '0; e.pcsrc = 2'b10; e.pcwrite = 1'b1;
        cyc("jump", 1'b0, op, rnd4(), rnd1(), rnd1(), e);
      end
      default: res = 1;
    endcase
  endtask

  task automatic halt_then_reset(input int cycles, input bit be);
    out_t e;
    e = '0; e.halted = 1'b1; e.bus_err = be;
    repeat (cycles) cyc(be ? "halt_buserr" : "halt_illegal", 1'b0, rnd4(), rnd4(), rnd1(), rnd1(), e);
    cyc("reset_from_halt", 1'b1, rnd4(), rnd4(), rnd1(), rnd1(), '0);
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 19);
    if (r < 12) return 0;
    if (r < 16) return $urandom_range(1, 3);
    if (r < 18) return WAIT_MAX;
    if (r < 19) return WAIT_MAX - 1;
    return WAIT_MAX + 1;
  endfunction

  initial begin
    int  res;
    bit  to;
    out_t e;
    logic [3:0] op;
    @(posedge clk_i);
    #1;
    cyc("reset", 1'b1, rnd4(), rnd4(), rnd1(), 1'b1, '0);
    cyc("reset", 1'b1, rnd4(), rnd4(), rnd1(), 1'b1, '0);

    run_instr(4'h2, rnd4(), rnd1(), 0, 0, res);
    run_instr(4'h4, rnd4(), 1'b1, 0, 0, res);
    run_instr(4'h4, rnd4(), 1'b0, 0, 0, res);
    run_instr(4'h1, rnd4(), rnd1(), 3, 0, res);
    run_instr(4'h0, 4'h5, rnd1(), 0, 0, res);
    run_instr(4'h2, rnd4(), rnd1(), 0, WAIT_MAX, res);

    run_instr(4'h3, rnd4(), rnd1(), 0, WAIT_MAX + 1, res);
    halt_then_reset(3, res == 2);

    run_instr(4'hF, rnd4(), rnd1(), 0, 0, res);
    halt_then_reset(20, res == 2);

    // Reset lands while a store is waiting on memory
    fetch_phase(0, to);
    e = '0; e.alusrcb = 2'b11;
    cyc("decode", 1'b0, 4'h3, rnd4(), rnd1(), rnd1(), e);
    e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
    cyc("memadr", 1'b0, 4'h3, rnd4(), rnd1(), rnd1(), e);
    e = '0; e.iord = 1'b1; e.memwrite = 1'b1;
    cyc("memwr", 1'b0, 4'h3, rnd4(), rnd1(), 1'b0, e);
    cyc("reset_in_memwr", 1'b1, 4'h3, rnd4(), rnd1(), 1'b0, '0);
    run_instr(4'h5, rnd4(), rnd1(), 0, 0, res);

    for (int k = 0; k < 200; k++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      run_instr(op, rnd4(), rnd1(), pick_wait(), pick_wait(), res);
      if (res != 0) halt_then_reset($urandom_range(1, 4), res == 2);
    end

    @(negedge clk_i);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
